hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Pipeline hold/flush controller for the 5-stage RISC-V core; the stall-side counterpart of the EXE-stage bypass logic.
- Bypassing resolves hazards by selecting operands. This block resolves the hazards bypassing cannot fix by generating write-enables and bubble/flush controls for PC and every pipeline register:
  - load-use hazards;
  - taken-branch wrong-path instructions;
  - multi-cycle data-memory waits, with timeout detection.
- Sits in ID-stage control, beside the register-file read logic.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive data-memory wait cycles before the sticky timeout is raised (legal range 2..65535).
- CNT_W, 32: width of the performance counters; used only with HAZARD_PERF_CNT_EN.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; synchronous and active-high, sampled on the rising edge of clk_i.
- IFID_RS1  in  5  rs1 of the instruction in ID.
- IFID_RS2  in  5  rs2 of the instruction in ID.
- IFID_UseRS1  in  1  ID instruction reads rs1.
- IFID_UseRS2  in  1  ID instruction reads rs2.
- IDEXE_RD  in  5  rd of the instruction in EXE.
- IDEXE_MemRead  in  1  EXE instruction is a load.
- EXE_BranchTaken  in  1  branch/jump resolved taken in EXE this cycle.
- MEM_Req  in  1  MEM-stage instruction accesses data memory.
- DMEM_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC register load enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  IF/ID register loads a NOP.
- IDEXE_Write  out  1  ID/EXE register load enable.
- IDEXE_Flush  out  1  ID/EXE register loads a bubble (all control bits zero).
- EXEMEM_Write  out  1  EXE/MEM register load enable.
- MEMWB_Flush  out  1  MEM/WB register loads a bubble.
- Timeout  out  1  sticky data-memory timeout error.

Behaviour:
- State register with states RUN, MEM_WAIT, HALT. Wait counter is ceil(log2(MEM_TIMEOUT+1)) bits. Outputs are combinational from state plus inputs (zero-latency stall).
- Normal output values: all Write enables = 1, all Flush outputs = 0.
- Reset (rst_i = 1 at an edge): state := RUN, counter := 0.
  - While rst_i is high, the outputs are forced to: all Write enables 0, all Flush outputs 0, Timeout 0.
  - Reset mid-wait or in HALT returns to RUN in the next cycle.
- Freeze pattern: PC_Write = IFID_Write = IDEXE_Write = EXEMEM_Write = 0, MEMWB_Flush = 1, IFID_Flush = IDEXE_Flush = 0.
- Output priority, highest first: freeze > branch flush > load-use stall > normal.
- RUN:
  - MEM_Req=1 and DMEM_Ready=0:
    - This cycle: freeze.
    - Next state: MEM_WAIT, counter := 1.
  - MEM_Req=1 and DMEM_Ready=1: no stall.
  - EXE_BranchTaken=1:
    - IFID_Flush = 1 and IDEXE_Flush = 1.
    - PC_Write = 1 (PC loads the branch target).
    - Any load-use condition is ignored, because the ID instruction is discarded.
  - Load-use condition: IDEXE_MemRead=1, IDEXE_RD != 0, and (IDEXE_RD == IFID_RS1 with IFID_UseRS1=1, or IDEXE_RD == IFID_RS2 with IFID_UseRS2=1).
    - This cycle: PC_Write = 0, IFID_Write = 0, IDEXE_Flush = 1.
    - Exactly one bubble per hazard. The next cycle's EXE holds the bubble (MemRead=0), so the stall does not repeat. The load result then reaches the consumer via MEM/WB bypass.
  - x0 never causes a stall.
- MEM_WAIT:
  - DMEM_Ready=1: release this cycle.
    - Freeze is deasserted and the RUN-priority rules apply to the same-cycle inputs.
    - A taken branch held in EXE during the wait flushes in this release cycle.
    - Next state: RUN, counter := 0.
  - DMEM_Ready=0: freeze. EXE_BranchTaken and load-use are ignored; no flush is emitted during freeze.
    - counter < MEM_TIMEOUT: counter increments.
    - counter == MEM_TIMEOUT: next state HALT.
- HALT:
  - Freeze permanently; Timeout = 1.
  - Exits only via rst_i; DMEM_Ready is ignored.
- Counter never wraps; it saturates at MEM_TIMEOUT.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports StallCycles (CNT_W) and FlushCount (CNT_W). Both reset to 0 and saturate at all-ones.
  - StallCycles increments in every cycle where freeze or a load-use stall is asserted, including HALT cycles.
  - FlushCount increments in every cycle where the branch flush is asserted.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: IDEXE_MemRead=1, IDEXE_RD=5, IFID_RS2=5, IFID_UseRS2=1 -> that cycle PC_Write=0, IFID_Write=0, IDEXE_Flush=1; next cycle (MemRead=0) all normal.
- x0 and unused source: IDEXE_RD=0 with RS1=0; then RD=7, RS1=7, UseRS1=0 -> no stall in either case.
- Branch vs. load-use: EXE_BranchTaken=1 together with a load-use match -> IFID_Flush=1, IDEXE_Flush=1, PC_Write=1, IFID_Write=1.
- Memory wait with branch: MEM_Req=1, DMEM_Ready low for 3 cycles then high, EXE_BranchTaken=1 throughout -> freeze for 3 cycles with no flush; in the release cycle IFID_Flush=IDEXE_Flush=1; then state RUN.
- Timeout: MEM_TIMEOUT=4, DMEM_Ready held 0 -> Timeout=1 from the 6th cycle after MEM_Req first rises (first stall in RUN, 4 counted MEM_WAIT cycles, then HALT). A later DMEM_Ready=1 has no effect; rst_i=1 for one cycle -> Timeout=0, state RUN.
- Perf counters (HAZARD_PERF_CNT_EN defined): 1 load-use stall + 3 wait cycles + 1 branch flush -> StallCycles=4, FlushCount=1.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hold/flush control bundle between the pipeline and hazard_stall_unit.
// Perf-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0] IFID_RS1;
  logic [4:0] IFID_RS2;
  logic       IFID_UseRS1;
  logic       IFID_UseRS2;
  logic [4:0] IDEXE_RD;
  logic       IDEXE_MemRead;
  logic       EXE_BranchTaken;
  logic       MEM_Req;
  logic       DMEM_Ready;
  logic       PC_Write;
  logic       IFID_Write;
  logic       IFID_Flush;
  logic       IDEXE_Write;
  logic       IDEXE_Flush;
  logic       EXEMEM_Write;
  logic       MEMWB_Flush;
  logic       Timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  modport master (
    output IFID_RS1, IFID_RS2, IFID_UseRS1, IFID_UseRS2, IDEXE_RD, IDEXE_MemRead,
    output EXE_BranchTaken, MEM_Req, DMEM_Ready,
`ifdef HAZARD_PERF_CNT_EN
    input  StallCycles, FlushCount,
`endif
    input  PC_Write, IFID_Write, IFID_Flush, IDEXE_Write, IDEXE_Flush, EXEMEM_Write,
    input  MEMWB_Flush, Timeout
  );

  modport slave (
    input  IFID_RS1, IFID_RS2, IFID_UseRS1, IFID_UseRS2, IDEXE_RD, IDEXE_MemRead,
    input  EXE_BranchTaken, MEM_Req, DMEM_Ready,
`ifdef HAZARD_PERF_CNT_EN
    output StallCycles, FlushCount,
`endif
    output PC_Write, IFID_Write, IFID_Flush, IDEXE_Write, IDEXE_Flush, EXEMEM_Write,
    output MEMWB_Flush, Timeout
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hold/flush controller: load-use stall, branch flush, data-memory wait with timeout.
// Optional perf counters (StallCycles, FlushCount) enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_stall_unit_if.slave hz
);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_params
    $error("MEM_TIMEOUT must be 2..65535 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            freeze;
  logic            branch;
  logic            hazard;
  logic            load_use;

  always_comb begin
    freeze = 1'b0;
    unique case (state_q)
      StRun:     freeze = hz.MEM_Req && !hz.DMEM_Ready;
      StMemWait: freeze = !hz.DMEM_Ready;
      StHalt:    freeze = 1'b1;
      default:   freeze = 1'b0;
    endcase
  end

  // Register x0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = hz.IDEXE_MemRead && (hz.IDEXE_RD != 5'd0) &&
                  ((hz.IFID_UseRS1 && (hz.IDEXE_RD == hz.IFID_RS1)) ||
                   (hz.IFID_UseRS2 && (hz.IDEXE_RD == hz.IFID_RS2)));
  assign branch   = !freeze && hz.EXE_BranchTaken;
  assign load_use = !freeze && !branch && hazard;

  always_comb begin
    hz.PC_Write     = 1'b0;
    hz.IFID_Write   = 1'b0;
    hz.IFID_Flush   = 1'b0;
    hz.IDEXE_Write  = 1'b0;
    hz.IDEXE_Flush  = 1'b0;
    hz.EXEMEM_Write = 1'b0;
    hz.MEMWB_Flush  = 1'b0;
    hz.Timeout      = 1'b0;
    if (!rst_i) begin
      hz.PC_Write     = !freeze && !load_use;
      hz.IFID_Write   = !freeze && !load_use;
      hz.IFID_Flush   = branch;
      hz.IDEXE_Write  = !freeze;
      hz.IDEXE_Flush  = branch || load_use;
      hz.EXEMEM_Write = !freeze;
      hz.MEMWB_Flush  = freeze;
      hz.Timeout      = (state_q == StHalt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.MEM_Req && !hz.DMEM_Ready) begin
            state_q <= StMemWait;
            cnt_q   <= CntOne;
          end
        end
        StMemWait: begin
          if (hz.DMEM_Ready) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StHalt;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((freeze || load_use) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (branch && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.StallCycles = stall_q;
  assign hz.FlushCount  = flush_q;
`endif
endmodule
